pwm_nivel_motor: RTL and testbench
==================================

// Module: pwm_nivel_motor
// PURPOSE
//  Downstream stage of the 2-bit saturating speed-level counter of the drone
//  project. Consumes the 2-bit level (nivel, 0..3) and drives one
//  motor-control PWM line.
//  Level changes take effect only on period boundaries, so no runt or glitch
//  pulses reach the ESC.
//  Also emits a one-cycle end-of-period strobe for telemetry/sequencing logic.
// PARAMETERS
//  PERIODO  50000  PWM period in clock cycles (>=2); 1 kHz at 50 MHz
//  DUTY1    12500  high time for level 1, cycles (<=PERIODO)
//  DUTY2    25000  high time for level 2, cycles (<=PERIODO)
//  DUTY3    37500  high time for level 3, cycles (<=PERIODO); level 0 is always 0
//  CW       16     period counter width, must satisfy 2**CW >= PERIODO
// PORTS
//  clock        in   1   system clock; all state updates on posedge
//  clr          in   1   asynchronous active-low reset
//  enable       in   1   1 = run PWM, 0 = stop
//  nivel        in   2   requested level; taken from the level counter Q
//  pwm          out  1   registered PWM output
//  fim_periodo  out  1   1-cycle strobe on last cycle of each period
//  nivel_ativo  out  2   level currently applied to pwm
//  rodando      out  1   1 while FSM is in RUN
// BEHAVIOUR
//  Reset (clr=0, async): state=IDLE, cont=0, pwm=0, fim_periodo=0,
//  nivel_ativo=0, rodando=0.
//  FSM states:
//   IDLE: cont held at 0, pwm=0, fim_periodo=0.
//     enable=1 -> RUN; on that same edge nivel_ativo<=nivel (RAMPA_EN: see below).
//   RUN: cont counts 0..PERIODO-1 and wraps to 0.
//     Cycle k of a period (k=cont): pwm=1 iff k < DUTY[nivel_ativo].
//     Latency: pwm is registered via lookahead compare; the first RUN cycle is
//     k=0, so pwm rises on the same edge that enters RUN if DUTY>0.
//     fim_periodo=1 exactly while cont==PERIODO-1.
//     On the edge leaving cont==PERIODO-1: cont<=0 and nivel_ativo updates.
//     nivel changes mid-period are ignored until that boundary; only the value
//     present on the boundary edge counts.
//     enable=0 at any point -> IDLE on the next edge; pwm=0 from that edge
//     (immediate stop, partial period allowed).
//  DUTYn==PERIODO gives pwm constantly 1; DUTYn==0 gives constantly 0.
//  nivel_ativo=0 in RUN: pwm=0 but cont and fim_periodo keep running.
//  clr mid-period: all outputs return to reset values asynchronously; the
//  first period after release starts at cont=0.
//  enable toggled 1->0->1 in consecutive cycles: RUN->IDLE->RUN, and cont
//  restarts at 0.
// CONFIGURATION
//  RAMPA_EN (macro) undefined: nivel_ativo<=nivel at each boundary (direct jump).
//  RAMPA_EN defined: each boundary moves nivel_ativo one step toward nivel
//   (+1, -1 or hold), so 0->3 takes 3 periods.
//   On IDLE->RUN, nivel_ativo starts at 0 and ramps up from there.
//   On RUN->IDLE, nivel_ativo is forced to 0.
// STRUCTURE
//  Shared include pwm_nivel_defs.vh holds:
//   - state encodings: ST_IDLE=1'b0, ST_RUN=1'b1
//   - default PERIODO/DUTY constants shared with top-level instantiation
//  Sub-module contador_periodo_pwm: modulo-PERIODO counter with synchronous
//   zeroing input (state==IDLE) and terminal-count output. Its terminal-count
//   output drives fim_periodo.
//  Top module holds the FSM, level register/ramp, duty mux and pwm register.
// TESTING (bench uses PERIODO=10, DUTY1=3, DUTY2=5, DUTY3=8)
//  1. Reset, then enable=1, nivel=2 -> pwm high 5 cycles, low 5 cycles,
//     repeating; fim_periodo on every 10th cycle.
//  2. nivel 1->3 at cycle 4 of a period -> rest of that period keeps
//     DUTY1 (pwm already 0); next period has 8 high cycles.
//  3. enable=0 at k=2 with nivel=3 -> pwm=0 from the next edge, rodando=0;
//     re-enable -> period restarts at k=0 with pwm high.
//  4. nivel=0, then nivel=3 -> pwm stuck 0 / stuck high for 8 of 10 cycles;
//     then DUTY3=10 run -> pwm constantly 1 across boundaries.
//  5. clr pulsed low at k=6, level 3 -> pwm=0, nivel_ativo=0 immediately;
//     after release with enable=1 -> new period from k=0.
//  6. RAMPA_EN defined, nivel=3 from IDLE -> consecutive periods show
//     3, 5, 8 high cycles; nivel 3->0 then steps 8, 5, 3, 0.

Source files
------------

// File: rtl/pwm_nivel_motor_pkg.sv
// Shared types and defaults for the motor-level PWM stage (state encoding, default timing).
// The ramp helper is only used when the RAMPA_EN macro is defined.
package pwm_nivel_motor_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } estado_t;

   // 1 kHz PWM from a 50 MHz clock, with quarter-step duties per level
   localparam int PERIODO_PADRAO = 50000;
   localparam int DUTY1_PADRAO   = 12500;
   localparam int DUTY2_PADRAO   = 25000;
   localparam int DUTY3_PADRAO   = 37500;
   localparam int CW_PADRAO      = 16;

   function automatic logic [1:0] passoNivel(input logic [1:0] atual, input logic [1:0] alvo);
      if (alvo > atual) begin
         return atual + 2'd1;
      end else if (alvo < atual) begin
         return atual - 2'd1;
      end
      return atual;
   endfunction

endpackage

// File: rtl/pwm_nivel_motor_contador_periodo_pwm.sv
// Modulo-PERIODO period counter with synchronous zeroing and terminal-count flag.
// Exposes its next value so the parent can register pwm one cycle ahead.
module contador_periodo_pwm #(
   parameter int PERIODO = 50000,
   parameter int CW      = 16
) (
   input  logic          clock,
   input  logic          clr,
   input  logic          zerar_i,
   output logic [CW-1:0] contProx_o,
   output logic          terminal_o
);

   localparam logic [CW-1:0] ULTIMO = CW'(PERIODO - 1);

   logic [CW-1:0] cont_q;
   logic [CW-1:0] cont_d;

   always_comb begin
      terminal_o = (cont_q == ULTIMO);
      if (zerar_i || terminal_o) begin
         cont_d = '0;
      end else begin
         cont_d = cont_q + CW'(1);
      end
      contProx_o = cont_d;
   end

   always_ff @(posedge clock or negedge clr) begin
      if (!clr) begin
         cont_q <= '0;
      end else begin
         cont_q <= cont_d;
      end
   end

endmodule

// File: rtl/pwm_nivel_motor.sv
// Level-driven motor PWM: FSM, boundary-synchronised level register, duty mux, registered pwm.
// Optional feature: define RAMPA_EN to step the applied level by one per period.
module pwm_nivel_motor
   import pwm_nivel_motor_pkg::*;
#(
   parameter int PERIODO = PERIODO_PADRAO,
   parameter int DUTY1   = DUTY1_PADRAO,
   parameter int DUTY2   = DUTY2_PADRAO,
   parameter int DUTY3   = DUTY3_PADRAO,
   parameter int CW      = CW_PADRAO
) (
   input  logic       clock,
   input  logic       clr,
   input  logic       enable,
   input  logic [1:0] nivel,
   output logic       pwm,
   output logic       fim_periodo,
   output logic [1:0] nivel_ativo,
   output logic       rodando
);

   estado_t       estado_q, estado_d;
   logic [1:0]    nivelAtivo_q, nivelAtivo_d;
   logic          pwm_q, pwm_d;
   logic          zerar;
   logic          terminal;
   logic [CW-1:0] contProx;
   logic [CW:0]   dutyProx;

   // Zeroing on !enable keeps cont at 0 throughout IDLE, including the edge that leaves RUN
   assign zerar = (estado_q == ST_IDLE) || !enable;

   contador_periodo_pwm #(
      .PERIODO (PERIODO),
      .CW      (CW)
   ) uContador (
      .clock      (clock),
      .clr        (clr),
      .zerar_i    (zerar),
      .contProx_o (contProx),
      .terminal_o (terminal)
   );

   always_comb begin
      estado_d     = estado_q;
      nivelAtivo_d = nivelAtivo_q;
      case (estado_q)
         ST_IDLE: begin
            if (enable) begin
               estado_d = ST_RUN;
`ifdef RAMPA_EN
               nivelAtivo_d = passoNivel(2'd0, nivel);
`else
               nivelAtivo_d = nivel;
`endif
            end
         end
         ST_RUN: begin
            if (!enable) begin
               estado_d = ST_IDLE;
`ifdef RAMPA_EN
               nivelAtivo_d = 2'd0;
`endif
            end else if (terminal) begin
`ifdef RAMPA_EN
               nivelAtivo_d = passoNivel(nivelAtivo_q, nivel);
`else
               nivelAtivo_d = nivel;
`endif
            end
         end
         default: estado_d = ST_IDLE;
      endcase
   end

   // Lookahead compare: next cycle's count against next cycle's level gives a registered pwm
   always_comb begin
      case (nivelAtivo_d)
         2'd1:    dutyProx = (CW+1)'(DUTY1);
         2'd2:    dutyProx = (CW+1)'(DUTY2);
         2'd3:    dutyProx = (CW+1)'(DUTY3);
         default: dutyProx = '0;
      endcase
      pwm_d = (estado_d == ST_RUN) && ({1'b0, contProx} < dutyProx);
   end

   always_ff @(posedge clock or negedge clr) begin
      if (!clr) begin
         estado_q     <= ST_IDLE;
         nivelAtivo_q <= 2'd0;
         pwm_q        <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         nivelAtivo_q <= nivelAtivo_d;
         pwm_q        <= pwm_d;
      end
   end

   assign pwm         = pwm_q;
   assign fim_periodo = terminal;
   assign nivel_ativo = nivelAtivo_q;
   assign rodando     = (estado_q == ST_RUN);

endmodule

// File: tb/tb_pwm_nivel_motor.sv
// Self-checking bench for pwm_nivel_motor: directed scenarios plus random traffic against a period-level model.
// Honours RAMPA_EN the same way as the design; a second instance uses DUTY3 equal to the period.
module tb_pwm_nivel_motor;

   localparam int P = 10;

   logic       clock = 1'b0;
   logic       clr;
   logic       enable;
   logic [1:0] nivel;
   logic       pwm, fimPeriodo, rodando;
   logic [1:0] nivelAtivo;
   logic       pwm2, fimPeriodo2, rodando2;
   logic [1:0] nivelAtivo2;

`ifdef RAMPA_EN
   localparam bit RAMPA = 1'b1;
`else
   localparam bit RAMPA = 1'b0;
`endif

   int nChecks = 0;
   int nFails  = 0;
   int dutyTab[4]  = '{0, 3, 5, 8};
   int dutyTab2[4] = '{0, 3, 5, 10};

   bit mRun;
   int mK;
   int mLvl;

   always #5 clock = ~clock;

   pwm_nivel_motor #(.PERIODO(P), .DUTY1(3), .DUTY2(5), .DUTY3(8), .CW(4)) dut (
      .clock(clock), .clr(clr), .enable(enable), .nivel(nivel),
      .pwm(pwm), .fim_periodo(fimPeriodo), .nivel_ativo(nivelAtivo), .rodando(rodando)
   );

   pwm_nivel_motor #(.PERIODO(P), .DUTY1(3), .DUTY2(5), .DUTY3(10), .CW(4)) dutCheio (
      .clock(clock), .clr(clr), .enable(enable), .nivel(nivel),
      .pwm(pwm2), .fim_periodo(fimPeriodo2), .nivel_ativo(nivelAtivo2), .rodando(rodando2)
   );

   task automatic checkOutput(input string tag, input int got, input int exp);
      nChecks++;
      if (got != exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t, k=%0d)", tag, got, exp, $time, mK);
      end
   endtask

   function automatic int alvoNivel(input int atual, input int pedido);
      if (!RAMPA) return pedido;
      if (pedido > atual) return atual + 1;
      if (pedido < atual) return atual - 1;
      return atual;
   endfunction

   // One clock edge of the behaviour as the model understands it
   task automatic modelStep();
      if (!clr) begin
         mRun = 0; mK = 0; mLvl = 0;
      end else if (mRun && enable) begin
         if (mK == P - 1) begin
            mK = 0;
            mLvl = alvoNivel(mLvl, int'(nivel));
         end else begin
            mK++;
         end
      end else if (!mRun && enable) begin
         mRun = 1; mK = 0;
         mLvl = alvoNivel(0, int'(nivel));
      end else begin
         if (mRun && RAMPA) mLvl = 0;
         mRun = 0; mK = 0;
      end
   endtask

   task automatic checkAll();
      checkOutput("pwm",         int'(pwm),         int'(mRun && mK < dutyTab[mLvl]));
      checkOutput("fim_periodo", int'(fimPeriodo),  int'(mRun && mK == P - 1));
      checkOutput("nivel_ativo", int'(nivelAtivo),  mLvl);
      checkOutput("rodando",     int'(rodando),     int'(mRun));
      checkOutput("pwm_cheio",   int'(pwm2),        int'(mRun && mK < dutyTab2[mLvl]));
      checkOutput("fim_cheio",   int'(fimPeriodo2), int'(mRun && mK == P - 1));
      checkOutput("nivel_cheio", int'(nivelAtivo2), mLvl);
      checkOutput("rod_cheio",   int'(rodando2),    int'(mRun));
   endtask

   task automatic applyStimulus(input logic en, input logic [1:0] nv);
      enable = en;
      nivel  = nv;
      @(posedge clock);
      modelStep();
      @(negedge clock);
      checkAll();
   endtask

   task automatic runUntilK(input int alvo, input logic [1:0] nv);
      int g = 0;
      while ((!mRun || mK != alvo) && g < 3 * P) begin
         applyStimulus(1'b1, nv);
         g++;
      end
      checkOutput("alinhamento", int'(g < 3 * P), 1);
   endtask

   initial begin
      logic       en;
      logic [1:0] nv;
      clr = 1'b0; enable = 1'b0; nivel = 2'd0;
      mRun = 0; mK = 0; mLvl = 0;
      #2;
      checkAll();
      @(negedge clock);
      clr = 1'b1;

      // Steady level 2, then a mid-period request that must wait for the boundary
      repeat (30) applyStimulus(1'b1, 2'd2);
      repeat (12) applyStimulus(1'b1, 2'd1);
      runUntilK(4, 2'd1);
      repeat (20) applyStimulus(1'b1, 2'd3);

      // Immediate stop at k=2, then restart from k=0
      runUntilK(2, 2'd3);
      repeat (2) applyStimulus(1'b0, 2'd3);
      repeat (12) applyStimulus(1'b1, 2'd3);
      applyStimulus(1'b0, 2'd3);
      repeat (5) applyStimulus(1'b1, 2'd3);

      // Level 0 keeps counting with pwm low; level 3 on the full-duty instance stays high
      repeat (25) applyStimulus(1'b1, 2'd0);
      repeat (25) applyStimulus(1'b1, 2'd3);

      // Asynchronous clear mid-period
      runUntilK(6, 2'd3);
      clr = 1'b0;
      #1;
      mRun = 0; mK = 0; mLvl = 0;
      checkAll();
      applyStimulus(1'b1, 2'd3);
      clr = 1'b1;
      repeat (12) applyStimulus(1'b1, 2'd3);

      // Climb from IDLE to 3, then drop to 0 (ramps when RAMPA_EN is defined)
      repeat (2) applyStimulus(1'b0, 2'd3);
      repeat (40) applyStimulus(1'b1, 2'd3);
      repeat (40) applyStimulus(1'b1, 2'd0);

      nv = 2'd1;
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 7) == 0) nv = 2'($urandom_range(0, 3));
         applyStimulus(en, nv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
